adc_avg_filter: RTL and testbench
=================================

# adc_avg_filter

Moving-average filter between the SPI ADC capture stage and the compare/UART stages. It takes each 8-bit ADC sample, presented as a one-cycle strobe on the cs_n-falling tick, and keeps the last 2^LOG2N samples in a circular window with a running sum. For every new sample it emits the truncated window mean, so the comparator and UART formatter see a de-noised value instead of the raw conversion.

## Interface
Parameters:
- DW, 8: sample width in bits.
- LOG2N, 3: log2 of the window length; window N = 2^LOG2N. Legal range 1..6.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset. **Asynchronous, active-low.** Clears all state.
- clear  in  1  synchronous window flush. One-cycle pulse; may be held.
- in_valid  in  1  one-cycle strobe; in_data is sampled on this cycle. Back-to-back strobes are legal.
- in_data  in  DW  raw ADC sample.
- out_valid  out  1  one-cycle strobe: out_data holds a new average.
- out_data  out  DW  window mean, truncated.
- full  out  1  high once N samples have been accepted since reset or clear.

## Operation
- State: FILL (reset state) and RUN.
  - FILL → RUN on the Nth accepted sample.
  - Any state → FILL on clear.
- Registers:
  - Window buffer: N×DW.
  - wr_ptr: LOG2N bits, wraps from N−1 to 0.
  - fill_cnt: LOG2N+1 bits, saturates at N.
  - sum: DW+LOG2N bits. It cannot overflow, because the maximum is N·(2^DW−1).
- On an accepted sample (in_valid=1, clear=0):
  - oldest = buf[wr_ptr] in RUN, and 0 in FILL.
  - sum_next = sum + in_data − oldest.
  - buf[wr_ptr] ← in_data.
  - wr_ptr ← wr_ptr+1 (mod N).
  - sum ← sum_next.
  - fill_cnt ← fill_cnt+1 (saturating).
- Output:
  - out_valid pulses only on samples accepted in RUN, or on the sample that completes FILL.
  - out_data ← sum_next >> LOG2N (truncation, no rounding).
  - During FILL, out_valid stays 0 and out_data holds its previous value.
- clear:
  - sum, wr_ptr and fill_cnt go to 0; the state goes to FILL; full goes to 0.
  - Buffer contents are not erased. They are masked by the FILL rule, where oldest = 0.
  - out_data holds its value.
  - clear has priority over in_valid: a sample presented in the same cycle as clear is dropped, and out_valid stays 0.
- in_data is ignored while in_valid=0.

## Timing
- Reset values: out_valid=0, out_data=0, full=0, state FILL, sum=0, wr_ptr=0, fill_cnt=0.
- Latency: out_valid/out_data are registered one cycle after the accepting in_valid edge.
- full rises in the same cycle as the first out_valid after FILL. It falls in the cycle after clear is sampled.
- Throughput: one sample per clock. With in_valid held high in RUN, out_valid is high every cycle.
- Reset asserted mid-window returns all state to reset values immediately (asynchronously). The next sample starts a fresh FILL.
- The buffer read of buf[wr_ptr] is combinational (asynchronous read). The write occurs on the same edge, so the read returns the old value.

## Structure
- Shared header/package `adc_avg_defs` holds:
  - state encodings ST_FILL/ST_RUN;
  - default DW/LOG2N;
  - the derived SUMW = DW+LOG2N.
- One sub-module, `avg_window_ram`:
  - N×DW register file;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr → rdata);
  - no reset on the storage array.
- The top-level filter holds the FSM, pointer, fill counter, sum and output registers.

## Test plan
All scenarios use DW=8, LOG2N=3.
- Reset/idle: assert n_rst=0 mid-run, then release → out_valid=0, out_data=0x00, full=0; no out_valid until 8 new samples.
- Fill and slide: samples 1,2,…,8 → the single out_valid comes after the 8th, with 0x04 (sum 36), and full=1; next sample 9 → 0x05 (sum 44); next sample 10 → 0x06 (sum 52).
- Saturation/width: 8 samples of 0xFF → 0xFF with no overflow; then 8 samples of 0x00 → outputs step down 0xDF, 0xBF, 0x9F, 0x7F, 0x5F, 0x3F, 0x1F, 0x00.
- Back-to-back: in_valid held high for 20 cycles with ramp data 0..19 → out_valid high for exactly 13 consecutive cycles; the first output is 0x03 (sum 28), the last is 0x0F (sum 124); wr_ptr wraps without a glitch.
- Clear mid-run:
  - In RUN, pulse clear together with in_valid (data 0x80) → sample dropped, no out_valid, full=0 on the next cycle.
  - Then 8 samples of 0x20 → the first output is 0x20; stale buffer contents must not leak into it.
- Sparse strobes: samples spaced by random 0–50 idle cycles → each output equals the truncated mean of the last 8 samples, checked against a scoreboard model.

Source files
------------

// File: rtl/adc_avg_filter_pkg.sv
// Shared definitions for the ADC moving-average filter: defaults, state encoding, sum width.
package adc_avg_defs;

  localparam int DEF_DW    = 8;
  localparam int DEF_LOG2N = 3;
  localparam int SUMW      = DEF_DW + DEF_LOG2N;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // N samples of (2^dw - 1) fit exactly in dw+log2n bits.
  function automatic int sum_width(input int dw, input int log2n);
    return dw + log2n;
  endfunction

endpackage

// File: rtl/adc_avg_filter_if.sv
// Sample-in / average-out bus between the ADC capture stage and the filter.
interface adc_avg_filter_if
  import adc_avg_defs::*;
#(
  parameter int DW = DEF_DW
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          full;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  full
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output full
  );

endinterface

// File: rtl/adc_avg_filter_ram.sv
// Window storage: register file with one synchronous write port and one asynchronous read port.
module avg_window_ram #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter over the last 2^LOG2N ADC samples; emits the truncated mean per sample.
module adc_avg_filter
  import adc_avg_defs::*;
#(
  parameter int DW    = DEF_DW,
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  adc_avg_filter_if.slave  bus
);

  localparam int              N        = 1 << LOG2N;
  localparam int              SW       = sum_width(DW, LOG2N);
  localparam logic [LOG2N:0]  CNT_FULL = (LOG2N+1)'(N);
  localparam logic [LOG2N:0]  CNT_LAST = (LOG2N+1)'(N - 1);

  state_t           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_wr_ptr;
  logic [LOG2N:0]   r_fill_cnt;
  logic [SW-1:0]    r_sum, w_sum_nxt;
  logic [DW-1:0]    w_rdata, w_oldest;
  logic             w_accept, w_fill_done, w_emit;
  logic             r_out_valid, r_full;
  logic [DW-1:0]    r_out_data;

  // Read and write share r_wr_ptr: the read sees the slot's old contents before this edge overwrites it.
  avg_window_ram #(.DW(DW), .AW(LOG2N)) u_ram (
    .clk   (clk),
    .we    (w_accept),
    .waddr (r_wr_ptr),
    .wdata (bus.in_data),
    .raddr (r_wr_ptr),
    .rdata (w_rdata)
  );

  always_comb begin
    w_accept    = bus.in_valid && !clear;
    w_fill_done = (r_state == ST_FILL) && (r_fill_cnt == CNT_LAST);
    // Stale buffer contents after clear are masked by treating the evicted sample as 0 while filling.
    w_oldest    = (r_state == ST_RUN) ? w_rdata : '0;
    w_sum_nxt   = r_sum + SW'(bus.in_data) - SW'(w_oldest);
    w_emit      = w_accept && ((r_state == ST_RUN) || w_fill_done);
    w_state_nxt = r_state;
    if (clear)                     w_state_nxt = ST_FILL;
    else if (w_accept && w_fill_done) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_full      <= 1'b0;
    end else begin
      r_full      <= (w_state_nxt == ST_RUN);
      r_out_valid <= w_emit;
      if (clear) begin
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        r_sum      <= '0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_sum    <= w_sum_nxt;
        if (r_fill_cnt != CNT_FULL) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_emit) r_out_data <= w_sum_nxt[SW-1:LOG2N];
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.full      = r_full;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter (DW=8, LOG2N=3) with a small window model for sparse traffic.
module tb_adc_avg_filter;

  logic clk = 1'b0;
  logic n_rst;
  logic clear;
  int   errors = 0;
  int   checks = 0;

  adc_avg_filter_if #(.DW(8)) bus ();

  adc_avg_filter #(.DW(8), .LOG2N(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle; outputs are sampled on the following falling edge.
  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  // Idle cycle with junk on in_data, which must be ignored.
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom_range(0, 255));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] step_down [8];
    int         vcount;
    int         q[$];
    int         sum;
    int         gap;
    logic [7:0] d;

    step_down = '{8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};

    n_rst        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_out_data",  32'(bus.out_data),  0);
    chk("reset_full",      32'(bus.full),      0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    idle();

    // Fill 1..8, then slide with 9 and 10
    for (int i = 1; i <= 7; i++) begin
      push(8'(i));
      chk("fill_no_valid", 32'(bus.out_valid), 0);
      chk("fill_not_full", 32'(bus.full), 0);
    end
    push(8'd8);
    chk("fill8_valid", 32'(bus.out_valid), 1);
    chk("fill8_data",  32'(bus.out_data),  32'h04);
    chk("fill8_full",  32'(bus.full),      1);
    push(8'd9);
    chk("slide9_valid", 32'(bus.out_valid), 1);
    chk("slide9_data",  32'(bus.out_data),  32'h05);
    push(8'd10);
    chk("slide10_data", 32'(bus.out_data), 32'h06);

    // Asynchronous reset mid-run, asserted away from any rising edge
    n_rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 0);
    chk("async_rst_data",  32'(bus.out_data),  0);
    chk("async_rst_full",  32'(bus.full),      0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    idle();

    // Saturation: 8 x 0xFF, then step down with 8 x 0x00
    for (int i = 0; i < 7; i++) begin
      push(8'hFF);
      chk("sat_fill_no_valid", 32'(bus.out_valid), 0);
    end
    push(8'hFF);
    chk("sat_ff_valid", 32'(bus.out_valid), 1);
    chk("sat_ff_data",  32'(bus.out_data),  32'hFF);
    for (int i = 0; i < 8; i++) begin
      push(8'h00);
      chk("sat_down_valid", 32'(bus.out_valid), 1);
      chk("sat_down_data",  32'(bus.out_data),  32'(step_down[i]));
    end
    idle();
    chk("idle_no_valid", 32'(bus.out_valid), 0);

    // Back-to-back ramp 0..19 after a flush
    clear = 1'b1;
    idle();
    clear = 1'b0;
    chk("clear_full_low", 32'(bus.full), 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      push(8'(i));
      if (bus.out_valid === 1'b1) vcount++;
      if (i >= 7) begin
        chk("ramp_valid", 32'(bus.out_valid), 1);
        chk("ramp_data",  32'(bus.out_data),  32'(i - 4));
      end else begin
        chk("ramp_no_valid", 32'(bus.out_valid), 0);
      end
    end
    idle();
    chk("ramp_end_no_valid", 32'(bus.out_valid), 0);
    chk("ramp_valid_count", 32'(vcount), 13);

    // clear together with a sample in RUN: sample dropped, output held
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h80;
    @(negedge clk);
    chk("clr_drop_valid", 32'(bus.out_valid), 0);
    chk("clr_full_low",   32'(bus.full),      0);
    chk("clr_data_hold",  32'(bus.out_data),  32'h0F);
    clear = 1'b0;
    idle();
    for (int i = 0; i < 7; i++) begin
      push(8'h20);
      chk("clr_fill_no_valid", 32'(bus.out_valid), 0);
    end
    push(8'h20);
    chk("clr_refill_valid", 32'(bus.out_valid), 1);
    chk("clr_refill_data",  32'(bus.out_data),  32'h20);
    chk("clr_refill_full",  32'(bus.full),      1);

    // Sparse random strobes against a window model
    clear = 1'b1;
    idle();
    clear = 1'b0;
    q.delete();
    for (int s = 0; s < 30; s++) begin
      gap = int'($urandom_range(0, 50));
      for (int g = 0; g < gap; g++) idle();
      if (gap > 0) chk("sparse_gap_no_valid", 32'(bus.out_valid), 0);
      d = 8'($urandom_range(0, 255));
      push(d);
      bus.in_valid = 1'b0;
      q.push_back(int'(d));
      if (q.size() > 8) void'(q.pop_front());
      if (q.size() == 8) begin
        sum = 0;
        foreach (q[k]) sum += q[k];
        chk("sparse_valid", 32'(bus.out_valid), 1);
        chk("sparse_data",  32'(bus.out_data),  32'(sum / 8));
        chk("sparse_full",  32'(bus.full),      1);
      end else begin
        chk("sparse_fill_no_valid", 32'(bus.out_valid), 0);
        chk("sparse_fill_not_full", 32'(bus.full),      0);
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
